// File: rtl/spi_slave_receiver_if.sv
// spi_slave_receiver_if: bit-event input window and decoded-frame outputs of the SD SPI command receiver.
interface spi_slave_receiver_if;
    logic [7:0]  io_InputBuffer;
    logic        io_BufferChanged;
    logic [7:0]  io_DataBlockSize;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic        io_CommandReadFinished;
    logic        io_ArgumentReadFinished;
    logic        io_ReadSuccess;
    logic [2:0]  io____state;
    modport master (
        output io_InputBuffer, io_BufferChanged, io_DataBlockSize,
        input  io_Command, io_CommandArgument, io_CommandReadFinished,
               io_ArgumentReadFinished, io_ReadSuccess, io____state
    );
    modport slave (
        input  io_InputBuffer, io_BufferChanged, io_DataBlockSize,
        output io_Command, io_CommandArgument, io_CommandReadFinished,
               io_ArgumentReadFinished, io_ReadSuccess, io____state
    );
endinterface

// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver: decodes 48-bit SD SPI command frames (start, cmd, arg, CRC7, end) one bit event at a time.
module spi_slave_receiver (
    input logic                  clock,
    input logic                  reset,
    spi_slave_receiver_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_ARG  = 3'd2,
        S_CRC  = 3'd3,
        S_END  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [6:0]  crc_q, crc_d;
    logic [6:0]  rx_crc_q, rx_crc_d;
    logic [7:0]  blk_q, blk_d;
    logic        cmd_done_q, cmd_done_d;
    logic        arg_done_q, arg_done_d;
    logic        ok_q, ok_d;

    logic ev, b, start;
    assign ev    = bus.io_BufferChanged;
    assign b     = bus.io_InputBuffer[0];
    assign start = bus.io_InputBuffer[1:0] == 2'b01;

    // Older window bits and the latched block size belong to the later data phase.
    logic unused_bits;
    assign unused_bits = ^{bus.io_InputBuffer[7:2], blk_q};

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
        return {c[5:0], 1'b0} ^ ((c[6] ^ d) ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            arg_q      <= '0;
            crc_q      <= '0;
            rx_crc_q   <= '0;
            blk_q      <= '0;
            cmd_done_q <= 1'b0;
            arg_done_q <= 1'b0;
            ok_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            crc_q      <= crc_d;
            rx_crc_q   <= rx_crc_d;
            blk_q      <= blk_d;
            cmd_done_q <= cmd_done_d;
            arg_done_q <= arg_done_d;
            ok_q       <= ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ev) begin
            case (state_q)
                S_IDLE:  state_d = start ? S_CMD : S_IDLE;
                S_CMD:   state_d = (cnt_q == 6'd5)  ? S_ARG : S_CMD;
                S_ARG:   state_d = (cnt_q == 6'd31) ? S_CRC : S_ARG;
                S_CRC:   state_d = (cnt_q == 6'd6)  ? S_END : S_CRC;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        crc_d      = crc_q;
        rx_crc_d   = rx_crc_q;
        blk_d      = blk_q;
        cmd_done_d = cmd_done_q;
        arg_done_d = arg_done_q;
        ok_d       = ok_q;
        if (ev) begin
            case (state_q)
                S_IDLE: if (start) begin
                    cnt_d      = '0;
                    cmd_done_d = 1'b0;
                    arg_done_d = 1'b0;
                    ok_d       = 1'b0;
                    crc_d      = crc7_step(crc7_step(7'd0, 1'b0), 1'b1);
                    blk_d      = bus.io_DataBlockSize;
                end
                S_CMD: begin
                    cmd_d      = {cmd_q[4:0], b};
                    crc_d      = crc7_step(crc_q, b);
                    cnt_d      = (cnt_q == 6'd5) ? 6'd0 : cnt_q + 6'd1;
                    cmd_done_d = cmd_done_q | (cnt_q == 6'd5);
                end
                S_ARG: begin
                    arg_d      = {arg_q[30:0], b};
                    crc_d      = crc7_step(crc_q, b);
                    cnt_d      = (cnt_q == 6'd31) ? 6'd0 : cnt_q + 6'd1;
                    arg_done_d = arg_done_q | (cnt_q == 6'd31);
                end
                S_CRC: begin
                    rx_crc_d = {rx_crc_q[5:0], b};
                    cnt_d    = (cnt_q == 6'd6) ? 6'd0 : cnt_q + 6'd1;
                end
                S_END:   ok_d = b && (rx_crc_q == crc_q);
                default: ;
            endcase
        end
    end

    assign bus.io_Command              = cmd_q;
    assign bus.io_CommandArgument      = arg_q;
    assign bus.io_CommandReadFinished  = cmd_done_q;
    assign bus.io_ArgumentReadFinished = arg_done_q;
    assign bus.io_ReadSuccess          = ok_q;
    assign bus.io____state             = state_q;
endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb_spi_slave_receiver: directed and random SD command frames checked by a queue-based scoreboard.
module tb_spi_slave_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_receiver_if bus();
    spi_slave_receiver dut (.clock(clk), .reset(rst), .bus(bus));

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic        ok;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         passed = 0;
    int         frame_bits = 0;
    logic [7:0] sr = 8'hFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // CRC7 as the remainder of (frame * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] model_crc(input logic [39:0] f);
        logic [46:0] r;
        r = {f, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        return r[6:0];
    endfunction

    task automatic send_bit(input logic b);
        sr = {sr[6:0], b};
        bus.io_InputBuffer   = sr;
        bus.io_DataBlockSize = 8'($urandom);
        bus.io_BufferChanged = 1'b1;
        frame_bits++;
        @(negedge clk);
        bus.io_BufferChanged = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f, input int nbits);
        frame_bits = 0;
        for (int i = 47; i > 47 - nbits; i--) send_bit(f[i]);
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    task automatic issue(input logic [47:0] f, input logic [5:0] cmd, input logic [31:0] arg, input logic ok);
        exp_t e;
        e.cmd = cmd;
        e.arg = arg;
        e.ok  = ok;
        q.push_back(e);
        send_frame(f, 48);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, 64'(bus.io____state), 64'd0);
        chk({tag, "_cmd"}, 64'(bus.io_Command), 64'd0);
        chk({tag, "_arg"}, 64'(bus.io_CommandArgument), 64'd0);
        chk({tag, "_flags"}, 64'({bus.io_CommandReadFinished, bus.io_ArgumentReadFinished, bus.io_ReadSuccess}), 64'd0);
    endtask

    initial begin
        logic [2:0] ps;
        logic pcf, paf;
        exp_t e;
        ps = 3'd0; pcf = 1'b0; paf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (ps == 3'd0 && bus.io____state == 3'd1)
                    chk("start_flags_clear", 64'({bus.io_CommandReadFinished, bus.io_ArgumentReadFinished, bus.io_ReadSuccess}), 64'd0);
                if (!pcf && bus.io_CommandReadFinished) chk("cmd_done_bit", 64'(frame_bits), 64'd8);
                if (!paf && bus.io_ArgumentReadFinished) chk("arg_done_bit", 64'(frame_bits), 64'd40);
                if (ps == 3'd4 && bus.io____state == 3'd0) begin
                    if (q.size() == 0) chk("unexpected_frame_end", 64'd1, 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("end_bit_index", 64'(frame_bits), 64'd48);
                        chk("command", 64'(bus.io_Command), 64'(e.cmd));
                        chk("argument", 64'(bus.io_CommandArgument), 64'(e.arg));
                        chk("done_flags", 64'({bus.io_CommandReadFinished, bus.io_ArgumentReadFinished}), 64'd3);
                        chk("read_success", 64'(bus.io_ReadSuccess), 64'(e.ok));
                    end
                end
            end
            ps  = bus.io____state;
            pcf = bus.io_CommandReadFinished;
            paf = bus.io_ArgumentReadFinished;
        end
    end

    initial begin
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic [6:0]  flip;
        logic        endb;
        bus.io_InputBuffer   = sr;
        bus.io_BufferChanged = 1'b0;
        bus.io_DataBlockSize = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("reset");
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk_idle_outputs("idle_ones");

        issue(48'h40_0000_0000_95, 6'd0, 32'h0, 1'b1);
        issue(48'h48_0000_01AA_87, 6'd8, 32'h0000_01AA, 1'b1);
        issue({2'b01, 6'b111011, 32'h0001_F791, 7'h7F, 1'b1}, 6'd59, 32'h0001_F791, 1'b0);
        issue(48'h40_0000_0000_94, 6'd0, 32'h0, 1'b0);
        issue(48'h40_0000_0000_95, 6'd0, 32'h0, 1'b1);

        // Abort a frame in ARG with a reset that coincides with a bit event.
        frame_bits = 0;
        for (int i = 47; i > 27; i--) send_bit(1'($bits(48'h48_0000_01AA_87) > 0) & 1'((48'h48_0000_01AA_87 >> i) & 48'd1));
        chk("mid_arg_state", 64'(bus.io____state), 64'd2);
        rst = 1'b1;
        bus.io_BufferChanged = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.io_BufferChanged = 1'b0;
        chk_idle_outputs("mid_reset");
        issue(48'h48_0000_01AA_87, 6'd8, 32'h0000_01AA, 1'b1);

        for (int n = 0; n < 24; n++) begin
            cmd  = 6'($urandom);
            arg  = $urandom;
            flip = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            endb = ($urandom_range(0, 7) != 0);
            issue({2'b01, cmd, arg, model_crc({2'b01, cmd, arg}) ^ flip, endb}, cmd, arg, endb && flip == 7'd0);
        end

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_receiver.md
SPI_SLAVE_RECEIVER -- requirements
Module: SpiSlaveReceiver

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: `clock` input, 1 bit, system clock, all state changes on its rising edge; `reset` input, 1 bit, synchronous, active-high.
REQ-002 `io_InputBuffer`  input  8  bit-shift window from the SPI front end; bit 0 is the newest received MOSI bit, bits 7:1 are older bits.
REQ-003 `io_BufferChanged`  input  1  one-cycle pulse per received SPI bit; each cycle it is high counts as one new bit in `io_InputBuffer[0]`.
REQ-004 `io_DataBlockSize`  input  8  data-block length for a later data phase; sampled at frame start into an internal register, no effect on command reception.
REQ-005 `io_Command`  output  6  command index of the last frame.
REQ-006 `io_CommandArgument`  output  32  argument of the last frame, MSB first on the line.
REQ-007 `io_CommandReadFinished`  output  1  high once the 6 command bits are captured.
REQ-008 `io_ArgumentReadFinished`  output  1  high once the 32 argument bits are captured.
REQ-009 `io_ReadSuccess`  output  1  high once a frame ends with a valid CRC7 and end bit.
REQ-010 `io____state`  output  3  current FSM state code, for debug.

Function
REQ-011 Frame format SHALL be the SD SPI command frame, 48 bits MSB first: start bit 0, transmission bit 1, CMD[5:0], ARG[31:0], CRC7[6:0], end bit 1.
REQ-012 All processing SHALL occur only in cycles where `io_BufferChanged`=1; registered outputs update on the same clock edge.
REQ-013 FSM codes: IDLE=0, CMD=1, ARG=2, CRC=3, END=4; codes 5-7 unused and SHALL return to IDLE.
REQ-014 IDLE: on a bit event with `io_InputBuffer[1:0]`=2'b01, go to CMD, clear the bit counter, clear all three flags, seed CRC7 with the bits 0,1, and latch `io_DataBlockSize`.
REQ-015 CMD: shift each bit into `io_Command` LSB-first-in (left shift).
  - After the 6th bit: set `io_CommandReadFinished`=1 and go to ARG.
REQ-016 ARG: left-shift each bit into `io_CommandArgument`.
  - After the 32nd bit: set `io_ArgumentReadFinished`=1 and go to CRC.
REQ-017 CRC7 SHALL run over the 40 bits start..ARG[0] with polynomial x^7+x^3+1 and initial value 0.
  - Serial update: fb = crc[6]^bit; crc = {crc[5:0],0} ^ (fb ? 7'h09 : 0).
REQ-018 CRC state: collect 7 received CRC bits, then go to END.
REQ-019 END: on the next bit, set `io_ReadSuccess`=1 iff the bit is 1 and the received CRC equals the computed CRC; otherwise leave it 0. Return to IDLE in both cases.
REQ-020 Outputs and flags SHALL hold their values until the next frame start (REQ-014) or reset.
REQ-021 In CMD, ARG and CRC every bit is data; start-pattern detection applies in IDLE only.
REQ-022 A frame truncated mid-way SHALL leave the FSM waiting in its current state; only reset recovers it.
REQ-023 Cycles with `io_BufferChanged`=0 SHALL change no state.

Reset
REQ-024 While `reset`=1 at a clock edge: FSM=IDLE, counters=0, CRC=0, `io_Command`=0, `io_CommandArgument`=0, and all flags=0.
REQ-025 Reset SHALL take priority over a simultaneous `io_BufferChanged` pulse and SHALL abort any frame in progress.

Verification
REQ-026 Reset, then 8 idle 1-bits -> state stays 0; all outputs 0.
REQ-027 Frame bytes 40 00 00 00 00 95 (CMD0) -> Command=0, Argument=0; CommandReadFinished rises after bit 8, ArgumentReadFinished after bit 40; ReadSuccess=1 after bit 48; state back to 0.
REQ-028 Frame 48 00 00 01 AA 87 (CMD8) -> Command=8, Argument=0x000001AA, ReadSuccess=1.
REQ-029 Start 0,1, CMD=6'b111011, ARG=0x0001F791, then CRC bits all 1 -> Command=59, Argument=0x0001F791, both Finished flags=1; after end bit 1, ReadSuccess=0 (CRC mismatch).
REQ-030 CMD0 frame with end bit 0 -> ReadSuccess=0; the next valid CMD0 frame clears the flags at its start, then sets ReadSuccess=1.
REQ-031 Reset asserted in the middle of ARG -> next cycle state=0 and all outputs 0; a following full frame decodes correctly.
